ahb_stream_bridge: RTL and testbench
====================================

# ahb_stream_bridge

Parametrised AHB-Lite slave that replaces the fixed single-register SoC interface in front of the stream compute engine. It adds address decoding and configurable data width and FIFO depths. Bus writes to DATA fill an input FIFO that feeds the engine over a valid/ready stream. Engine results fill an output FIFO that bus reads of DATA drain. Full/empty conditions produce either wait states or proper two-cycle ERROR responses, selected by mode, and a level-threshold interrupt is provided.

## Interface
- DATA_W, 32: bus and stream width; legal values 32 or 64.
- IN_DEPTH, 8: input FIFO depth; power of two, 2..128.
- OUT_DEPTH, 8: output FIFO depth; power of two, 2..128.
- HCLK  in  1  single clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL, HWRITE, HREADY  in  1 each  standard AHB-Lite.
- HADDR  in  4  byte address; bits [3:2] select the register.
- HTRANS  in  2; HSIZE, HBURST  in  3 each.
- HWDATA  in  DATA_W.
- HRDATA  out  DATA_W.
- HREADYOUT, HRESP  out  1 each.
- m_data  out  DATA_W, m_valid  out  1, m_ready  in  1: input-FIFO head toward the engine.
- s_data  in  DATA_W, s_valid  in  1, s_ready  out  1: engine results into the output FIFO.
- irq  out  1  registered level interrupt.

## Operation
- Register map (HADDR[3:2]):
  - 0 DATA (RW): a write pushes to the input FIFO; a read pops the output FIFO.
  - 1 STATUS (RO): [0] in_empty, [1] in_full, [2] out_empty, [3] out_full, [15:8] in_level, [23:16] out_level, rest 0.
  - 2 CTRL (RW): [0] clear, self-clearing and always reads 0; [1] block_mode; [2] irq_en; [15:8] irq_thresh.
  - 3: unmapped.
- Address phase is captured only when HSEL && HREADY && HTRANS[1]. IDLE and BUSY transfers get zero-wait OKAY.
- ERROR (two-cycle) is returned for:
  - HTRANS==SEQ (bursts unsupported);
  - HSIZE != log2(DATA_W/8);
  - address 3;
  - a write to STATUS;
  - with block_mode=0: a DATA write while in_full, or a DATA read while out_empty.
- Errored transfers cause no FIFO or register side effect.
- block_mode=1: a DATA write while in_full, or a DATA read while out_empty, holds HREADYOUT=0 until space or data exists, then completes OKAY. There is no timeout.
- Write to DATA: HWDATA is pushed in the cycle the data phase completes (HREADYOUT=1).
- Read of DATA: HRDATA = output-FIFO head (first-word fall-through), driven combinationally in the completing data-phase cycle. The pop happens on that edge.
- HRDATA = 0 outside a completing read data phase.
- m_valid = ~in_empty; input pop when m_valid && m_ready.
- s_ready = ~out_full; output push when s_valid && s_ready.
- A push is accepted only when the registered full flag is low, even if a pop occurs in the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO keeps the level unchanged.
- Pointers are log2(D) bits with wrap; level is log2(D)+1 bits. STATUS level fields are zero-extended.
- clear=1: both FIFOs are emptied on the edge after the CTRL write completes. An engine push or pop in that same cycle is discarded.
- irq is registered: irq <= irq_en && (out_level >= irq_thresh) && (irq_thresh != 0).

## Timing
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0;
  - m_valid=0, s_ready=1, irq=0;
  - CTRL=0, both FIFOs empty.
- ERROR sequence: cycle 1 HREADYOUT=0/HRESP=1; cycle 2 HREADYOUT=1/HRESP=1; then HRESP=0.
- Successful DATA or CTRL access has zero wait states.
- Pushed word appears on m_data/m_valid one cycle after the write data phase completes.
- Engine word accepted at edge N is readable in a data phase starting at edge N+1 or later.
- Block-mode stall releases in the cycle after the blocking flag clears. HREADYOUT returns to 1 that cycle and the access completes.
- irq follows out_level with one cycle of latency.
- Reset asserted mid-transfer or mid-stall:
  - outputs return to reset values immediately (asynchronously);
  - FIFO contents are lost;
  - the pending transfer is abandoned.

## Test plan
- Reset, then read STATUS -> HRDATA=0x00000005, OKAY, zero wait.
- With IN_DEPTH=8: write DATA 8x with m_ready=0, then a 9th write with block_mode=0 -> first 8 OKAY, STATUS in_level=8 and in_full=1; 9th gives two-cycle ERROR, level stays 8.
- block_mode=1 and out_empty: read DATA, then engine pushes 0xA5A5A5A5 four cycles later -> HREADYOUT low for 4 cycles, then HRDATA=0xA5A5A5A5 with OKAY; out_level returns to 0.
- SEQ transfer, HSIZE=byte, address 0xC, and a write to STATUS -> each gets two-cycle ERROR with no state change.
- CTRL=0x0304 (irq_en=1, thresh=3), engine pushes 3 words -> irq rises one cycle after the 3rd push; after one DATA read, irq falls one cycle later.
- Fill both FIFOs, then write CTRL=0x1 with a simultaneous s_valid -> next cycle STATUS=0x00000005 and CTRL reads back 0.

Source files
------------

// File: rtl/ahb_stream_bridge.sv
// AHB-Lite slave bridging DATA/STATUS/CTRL registers to a valid/ready stream engine.
// Input FIFO fed by bus writes, output FIFO drained by bus reads; ERROR or wait-state on full/empty.

module ahb_stream_bridge_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem[wr_ptr_q] <= wdata;
    end
endmodule

module ahb_stream_bridge #(
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic [3:0]        HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              irq
);
    localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;
    localparam logic [2:0] SIZE_OK = (DATA_W == 64) ? 3'd3 : 3'd2;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR} state_t;

    state_t      state_q, state_d;
    logic        dp_write_q, dp_write_d;
    logic [1:0]  dp_reg_q, dp_reg_d;
    logic        dp_serr_q, dp_serr_d;
    logic        block_q, block_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        irq_q, irq_d;

    logic              in_full, in_empty, out_full, out_empty;
    logic [IN_LW-1:0]  in_level;
    logic [OUT_LW-1:0] out_level;
    logic [DATA_W-1:0] out_head;
    logic              addr_ph, serr_a, fifo_block, done;
    logic              in_push, out_pop, ctrl_wr, clr;
    logic [31:0]       status_w, ctrl_w;
    logic              unused_bits;

    assign unused_bits = ^{HBURST, HADDR[1:0]};

    assign addr_ph = HSEL && HREADY && HTRANS[1];
    assign serr_a  = (HTRANS == 2'b11) || (HSIZE != SIZE_OK) || (HADDR[3:2] == 2'd3)
                   || (HWRITE && HADDR[3:2] == REG_STATUS);

    // A DATA access that would overflow/underflow: error or stall depending on block_mode
    assign fifo_block = (dp_reg_q == REG_DATA) && (dp_write_q ? in_full : out_empty);

    assign status_w = {8'h00, 8'(out_level), 8'(in_level), 4'h0,
                       out_full, out_empty, in_full, in_empty};
    assign ctrl_w   = {16'h0000, thresh_q, 5'b00000, irq_en_q, block_q, 1'b0};

    always_comb begin
        state_d    = state_q;
        dp_write_d = dp_write_q;
        dp_reg_d   = dp_reg_q;
        dp_serr_d  = dp_serr_q;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        HRDATA     = '0;
        done       = 1'b0;
        case (state_q)
            ST_DATA: begin
                if (dp_serr_q || (fifo_block && !block_q)) begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                end else if (fifo_block) begin
                    HREADYOUT = 1'b0;
                end else begin
                    done = 1'b1;
                    if (!dp_write_q) begin
                        case (dp_reg_q)
                            REG_DATA:   HRDATA = out_head;
                            REG_STATUS: HRDATA = DATA_W'(status_w);
                            REG_CTRL:   HRDATA = DATA_W'(ctrl_w);
                            default:    HRDATA = '0;
                        endcase
                    end
                end
            end
            ST_ERR:  HRESP = 1'b1;
            default: ;
        endcase

        if (state_q == ST_DATA && HRESP && !HREADYOUT) begin
            state_d = ST_ERR;
        end else if (HREADYOUT) begin
            if (addr_ph) begin
                state_d    = ST_DATA;
                dp_write_d = HWRITE;
                dp_reg_d   = HADDR[3:2];
                dp_serr_d  = serr_a;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        in_push  = done && dp_write_q && (dp_reg_q == REG_DATA);
        out_pop  = done && !dp_write_q && (dp_reg_q == REG_DATA);
        ctrl_wr  = done && dp_write_q && (dp_reg_q == REG_CTRL);
        clr      = ctrl_wr && HWDATA[0];
        block_d  = block_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (ctrl_wr) begin
            block_d  = HWDATA[1];
            irq_en_d = HWDATA[2];
            thresh_d = HWDATA[15:8];
        end
        irq_d = irq_en_q && (8'(out_level) >= thresh_q) && (thresh_q != 8'd0);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            dp_write_q <= 1'b0;
            dp_reg_q   <= 2'd0;
            dp_serr_q  <= 1'b0;
            block_q    <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= 8'd0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dp_write_q <= dp_write_d;
            dp_reg_q   <= dp_reg_d;
            dp_serr_q  <= dp_serr_d;
            block_q    <= block_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            irq_q      <= irq_d;
        end
    end

    ahb_stream_bridge_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(HCLK), .rst_n(HRESETn), .clr(clr),
        .push(in_push), .wdata(HWDATA),
        .pop(m_valid && m_ready), .rdata(m_data),
        .level(in_level), .full(in_full), .empty(in_empty)
    );

    ahb_stream_bridge_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(HCLK), .rst_n(HRESETn), .clr(clr),
        .push(s_valid && s_ready), .wdata(s_data),
        .pop(out_pop), .rdata(out_head),
        .level(out_level), .full(out_full), .empty(out_empty)
    );

    assign m_valid = ~in_empty;
    assign s_ready = ~out_full;
    assign irq     = irq_q;
endmodule

// File: tb/tb_ahb_stream_bridge.sv
// Directed bench for ahb_stream_bridge: register map, FIFO full/empty handling, irq, clear, reset.

module tb_ahb_stream_bridge;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0, HWRITE = 1'b0;
    logic        HREADY;
    logic [3:0]  HADDR = 4'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'd2, HBURST = 3'd0;
    logic [31:0] HWDATA = 32'h0;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;
    int stall;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahb_stream_bridge #(.DATA_W(32), .IN_DEPTH(8), .OUT_DEPTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Non-pipelined transfer: address phase, then data phase until HREADYOUT (bounded)
    task automatic xfer(input logic wr, input logic [3:0] addr, input logic [1:0] trans,
                        input logic [2:0] size, input logic [31:0] wd,
                        output logic [31:0] rd, output logic r1, output logic rl, output int w);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HWRITE = wr; HADDR = addr; HTRANS = trans; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HWDATA = wd;
        r1 = HRESP;
        w = 0;
        while (!HREADYOUT && w < 50) begin
            @(posedge HCLK); #1;
            w++;
        end
        rd = HRDATA;
        rl = HRESP;
    endtask

    task automatic wr_ok(input logic [3:0] addr, input logic [31:0] d, input string tag);
        logic [31:0] rd; logic r1, rl; int w;
        xfer(1'b1, addr, 2'b10, 3'd2, d, rd, r1, rl, w);
        check({tag, "_waits"}, w, 0);
        check({tag, "_resp"}, {31'b0, rl}, 0);
    endtask

    task automatic rd_chk(input logic [3:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] rd; logic r1, rl; int w;
        xfer(1'b0, addr, 2'b10, 3'd2, 32'h0, rd, r1, rl, w);
        check({tag, "_data"}, rd, exp);
        check({tag, "_waits"}, w, 0);
        check({tag, "_resp"}, {31'b0, rl}, 0);
    endtask

    task automatic err_chk(input logic wr, input logic [3:0] addr, input logic [1:0] trans,
                           input logic [2:0] size, input string tag);
        logic [31:0] rd; logic r1, rl; int w;
        xfer(wr, addr, trans, size, 32'hDEAD_BEEF, rd, r1, rl, w);
        check({tag, "_resp1"}, {31'b0, r1}, 1);
        check({tag, "_waits"}, w, 1);
        check({tag, "_resp2"}, {31'b0, rl}, 1);
        @(posedge HCLK); #1;
        check({tag, "_after"}, {30'b0, HREADYOUT, HRESP}, 32'h2);
    endtask

    initial begin
        // reset values
        #12;
        check("rst_hreadyout", {31'b0, HREADYOUT}, 1);
        check("rst_hresp", {31'b0, HRESP}, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_stream", {29'b0, m_valid, s_ready, irq}, 32'h2);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        rd_chk(4'h4, 32'h0000_0005, "status_reset");

        // fill input FIFO, engine not ready
        for (int i = 0; i < 8; i++) wr_ok(4'h0, 32'h100 + i, "in_fill");
        @(posedge HCLK); #1;
        check("m_head", m_data, 32'h100);
        check("m_valid_full", {31'b0, m_valid}, 1);
        rd_chk(4'h4, 32'h0000_0806, "status_in_full");
        err_chk(1'b1, 4'h0, 2'b10, 3'd2, "err_in_full");
        rd_chk(4'h4, 32'h0000_0806, "status_after_err");

        // engine drains in order
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_data", m_data, 32'h100 + i);
            @(posedge HCLK); #1;
        end
        check("drain_empty", {31'b0, m_valid}, 0);
        m_ready = 1'b0;

        // block-mode read stall
        wr_ok(4'h8, 32'h2, "ctrl_block");
        rd_chk(4'h8, 32'h2, "ctrl_rb");
        @(posedge HCLK); #1;
        HSEL = 1'b1; HWRITE = 1'b0; HADDR = 4'h0; HTRANS = 2'b10; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        stall = 0;
        while (!HREADYOUT && stall < 20) begin
            if (stall == 3) begin
                s_valid = 1'b1;
                s_data  = 32'hA5A5_A5A5;
            end
            @(posedge HCLK); #1;
            s_valid = 1'b0;
            stall++;
        end
        check("blk_stall", stall, 4);
        check("blk_data", HRDATA, 32'hA5A5_A5A5);
        check("blk_resp", {31'b0, HRESP}, 0);
        rd_chk(4'h4, 32'h0000_0005, "status_blk_done");

        // protocol errors, no side effects
        err_chk(1'b1, 4'h0, 2'b11, 3'd2, "err_seq");
        err_chk(1'b1, 4'h0, 2'b10, 3'd0, "err_size");
        err_chk(1'b0, 4'hC, 2'b10, 3'd2, "err_addr3");
        err_chk(1'b1, 4'h4, 2'b10, 3'd2, "err_wr_status");
        rd_chk(4'h4, 32'h0000_0005, "status_after_errs");
        rd_chk(4'h8, 32'h2, "ctrl_after_errs");

        // irq threshold
        wr_ok(4'h8, 32'h0304, "ctrl_irq");
        @(posedge HCLK); #1;
        s_valid = 1'b1; s_data = 32'h11;
        @(posedge HCLK); #1;
        s_data = 32'h22;
        @(posedge HCLK); #1;
        s_data = 32'h33;
        @(posedge HCLK); #1;
        s_valid = 1'b0;
        check("irq_lvl3_same", {31'b0, irq}, 0);
        @(posedge HCLK); #1;
        check("irq_rise", {31'b0, irq}, 1);
        rd_chk(4'h0, 32'h11, "rd_out_head");
        @(posedge HCLK); #1;
        check("irq_hold", {31'b0, irq}, 1);
        @(posedge HCLK); #1;
        check("irq_fall", {31'b0, irq}, 0);

        // fill both FIFOs, then clear with engine pushing
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 32'h40 + i;
            @(posedge HCLK); #1;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) wr_ok(4'h0, 32'h200 + i, "in_fill2");
        rd_chk(4'h4, 32'h0008_080A, "status_both_full");
        check("s_ready_full", {31'b0, s_ready}, 0);
        check("irq_full", {31'b0, irq}, 1);
        s_valid = 1'b1; s_data = 32'h99;
        wr_ok(4'h8, 32'h1, "ctrl_clear");
        s_valid = 1'b0;
        rd_chk(4'h4, 32'h0000_0005, "status_cleared");
        rd_chk(4'h8, 32'h0, "ctrl_cleared");
        check("irq_cleared", {31'b0, irq}, 0);

        // reset during a block-mode stall
        wr_ok(4'h8, 32'h2, "ctrl_block2");
        wr_ok(4'h0, 32'h77, "in_pre_rst");
        @(posedge HCLK); #1;
        HSEL = 1'b1; HWRITE = 1'b0; HADDR = 4'h0; HTRANS = 2'b10; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        check("stall_before_rst", {31'b0, HREADYOUT}, 0);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_mid_ready", {31'b0, HREADYOUT}, 1);
        check("rst_mid_resp", {31'b0, HRESP}, 0);
        check("rst_mid_mvalid", {31'b0, m_valid}, 0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        rd_chk(4'h4, 32'h0000_0005, "status_post_rst");
        rd_chk(4'h8, 32'h0, "ctrl_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
